timer_regresivo_bcd: RTL and testbench

TIMER_REGRESIVO_BCD -- requirements
Module: timer_regresivo_bcd

---
 rtl/timer_regresivo_bcd.sv | 109 ++++++++++
 tb/tb_timer_regresivo_bcd.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/timer_regresivo_bcd.sv
// timer_regresivo_bcd: HH:MM:SS packed-BCD countdown timer with a load/run/alarm FSM.
// One decrement every TICK_DIV clocks while running.
module timer_regresivo_bcd #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] ld_hora,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_seg,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [7:0] digit_TimerHORA,
    output logic [7:0] digit_TimerMIN,
    output logic [7:0] digit_TimerSEG,
    output logic       Alarma_on,
    output logic       running
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [7:0]      h_q, h_d, m_q, m_d, s_q, s_d;
    logic            alarm_q, run_q;
    logic            valid, tick, zero, one;

    // Units borrow from tens; tens 0 with units 0 wraps to `wrap`.
    function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [7:0] wrap);
        return (v[3:0] != 4'd0) ? v - 8'd1 :
               (v[7:4] != 4'd0) ? {v[7:4] - 4'd1, 4'h9} : wrap;
    endfunction

    always_comb begin
        valid = (ld_hora[3:0] <= 4'd9) && (ld_hora <= 8'h23) &&
                (ld_min[3:0] <= 4'd9) && (ld_min[7:4] <= 4'd5) &&
                (ld_seg[3:0] <= 4'd9) && (ld_seg[7:4] <= 4'd5);
        tick = pre_q == PW'(TICK_DIV - 1);
        zero = {h_q, m_q, s_q} == 24'h000000;
        one = {h_q, m_q, s_q} == 24'h000001;
        state_d = state_q;
        pre_d = '0;
        h_d = h_q;
        m_d = m_q;
        s_d = s_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (valid) {h_d, m_d, s_d} = {ld_hora, ld_min, ld_seg};
                end else if (start && !stop && !zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        s_d = dec_bcd(s_q, 8'h59);
                        m_d = (s_q == 8'h00) ? dec_bcd(m_q, 8'h59) : m_q;
                        h_d = (s_q == 8'h00 && m_q == 8'h00) ? dec_bcd(h_q, 8'h00) : h_q;
                        state_d = one ? ALARM : RUN;
                    end
                end
            end
            ALARM: begin
                if (load) begin
                    if (valid) begin
                        {h_d, m_d, s_d} = {ld_hora, ld_min, ld_seg};
                        state_d = IDLE;
                    end
                end else if (ack || stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pre_q <= '0;
            h_q <= 8'h00;
            m_q <= 8'h00;
            s_q <= 8'h00;
            alarm_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q <= pre_d;
            h_q <= h_d;
            m_q <= m_d;
            s_q <= s_d;
            alarm_q <= state_d == ALARM;
            run_q <= state_d == RUN;
        end
    end

    assign digit_TimerHORA = h_q;
    assign digit_TimerMIN = m_q;
    assign digit_TimerSEG = s_q;
    assign Alarma_on = alarm_q;
    assign running = run_q;
endmodule

// File: tb/tb_timer_regresivo_bcd.sv
// tb_timer_regresivo_bcd: directed checks of the countdown timer with TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_timer_regresivo_bcd;
    logic       CLK = 1'b0, RESET = 1'b1;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
    logic [7:0] ld_hora = 8'h00, ld_min = 8'h00, ld_seg = 8'h00;
    logic [7:0] digit_TimerHORA, digit_TimerMIN, digit_TimerSEG;
    logic       Alarma_on, running;
    logic [23:0] t;
    int n_cmp = 0, n_bad = 0;

    timer_regresivo_bcd #(.TICK_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET), .load(load),
        .ld_hora(ld_hora), .ld_min(ld_min), .ld_seg(ld_seg),
        .start(start), .stop(stop), .ack(ack),
        .digit_TimerHORA(digit_TimerHORA), .digit_TimerMIN(digit_TimerMIN),
        .digit_TimerSEG(digit_TimerSEG), .Alarma_on(Alarma_on), .running(running)
    );

    always #5 CLK = ~CLK;
    assign t = {digit_TimerHORA, digit_TimerMIN, digit_TimerSEG};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_load(input logic [23:0] v, input logic with_start);
        {ld_hora, ld_min, ld_seg} = v;
        load = 1'b1;
        start = with_start;
        wait_n(1);
        load = 1'b0;
        start = 1'b0;
    endtask

    task automatic pulse(input logic s_start, input logic s_stop, input logic s_ack);
        start = s_start;
        stop = s_stop;
        ack = s_ack;
        wait_n(1);
        {start, stop, ack} = 3'b000;
    endtask

    initial begin
        wait_n(2);
        chk("reset_time", t, 24'h000000);
        chk("reset_flags", {Alarma_on, running}, 2'b00);
        RESET = 1'b0;
        wait_n(1);
        // basic countdown to alarm
        do_load(24'h000003, 1'b0);
        chk("load3", t, 24'h000003);
        pulse(1, 0, 0);
        chk("run_flag", running, 1'b1);
        wait_n(3);
        chk("before_tick1", t, 24'h000003);
        wait_n(1);
        chk("tick1", t, 24'h000002);
        wait_n(4);
        chk("tick2", t, 24'h000001);
        chk("no_alarm_yet", Alarma_on, 1'b0);
        wait_n(4);
        chk("tick3", t, 24'h000000);
        chk("alarm_flags", {Alarma_on, running}, 2'b10);
        wait_n(3);
        chk("alarm_hold", {t, Alarma_on}, {24'h000000, 1'b1});
        pulse(0, 0, 1);
        chk("ack_clears", {Alarma_on, running}, 2'b00);
        // borrow chain
        do_load(24'h010000, 1'b0);
        pulse(1, 0, 0);
        wait_n(4);
        chk("borrow", t, 24'h005959);
        wait_n(4);
        chk("borrow_next", t, 24'h005958);
        pulse(0, 1, 0);
        chk("stop_flag", running, 1'b0);
        wait_n(8);
        chk("paused_hold", t, 24'h005958);
        // pause / resume with prescaler cleared
        do_load(24'h000010, 1'b0);
        pulse(1, 0, 0);
        wait_n(4);
        chk("pr_tick", t, 24'h000009);
        wait_n(1);
        pulse(0, 1, 0);
        chk("pr_paused", {t, running}, {24'h000009, 1'b0});
        wait_n(6);
        chk("pr_hold", t, 24'h000009);
        pulse(1, 0, 0);
        wait_n(3);
        chk("pr_early", t, 24'h000009);
        wait_n(1);
        chk("pr_resume", t, 24'h000008);
        do_load(24'h000030, 1'b0);
        chk("load_in_run", {t, running}, {24'h000008, 1'b1});
        pulse(0, 1, 0);
        // rejections
        do_load(24'h006000, 1'b0);
        chk("rej_min60", t, 24'h000008);
        do_load(24'h240000, 1'b0);
        chk("rej_h24", t, 24'h000008);
        do_load(24'h00000A, 1'b0);
        chk("rej_nibble", t, 24'h000008);
        do_load(24'h235959, 1'b0);
        chk("load_max", t, 24'h235959);
        do_load(24'h000000, 1'b0);
        pulse(1, 0, 0);
        chk("start_zero", running, 1'b0);
        // simultaneous cases
        do_load(24'h000005, 1'b0);
        pulse(1, 1, 0);
        chk("start_stop", running, 1'b0);
        do_load(24'h000007, 1'b1);
        chk("load_start", {t, running}, {24'h000007, 1'b0});
        pulse(0, 0, 1);
        chk("ack_idle", {t, running, Alarma_on}, {24'h000007, 2'b00});
        // asynchronous reset mid-run
        do_load(24'h000005, 1'b0);
        pulse(1, 0, 0);
        wait_n(2);
        #2 RESET = 1'b1;
        #1 chk("async_rst", {t, Alarma_on, running}, {24'h000000, 2'b00});
        wait_n(2);
        RESET = 1'b0;
        wait_n(6);
        chk("after_rst", {t, running}, {24'h000000, 1'b0});
        // alarm left by a valid load
        do_load(24'h000002, 1'b0);
        chk("first_after_rst", t, 24'h000002);
        pulse(1, 0, 0);
        wait_n(8);
        chk("alarm2", {t, Alarma_on}, {24'h000000, 1'b1});
        do_load(24'h990000, 1'b0);
        chk("alarm_rej", {t, Alarma_on}, {24'h000000, 1'b1});
        do_load(24'h000003, 1'b0);
        chk("alarm_load", {t, Alarma_on, running}, {24'h000003, 2'b00});
        // reset during alarm
        pulse(1, 0, 0);
        wait_n(12);
        chk("alarm3", Alarma_on, 1'b1);
        #2 RESET = 1'b1;
        #1 chk("rst_alarm", {t, Alarma_on, running}, {24'h000000, 2'b00});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
